// File: rtl/fp_mult_pkg.sv
// Shared types for the fp_mult datapath: rounding-mode encoding and exponent
// field constants used by the normalise/round back end.
package fp_mult_pkg;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rnd_mode_t;

    // All-ones exponent field encodes Inf; one below it is the largest finite.
    function automatic int exp_inf(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    function automatic int exp_max(input int exp_w);
        return (1 << exp_w) - 2;
    endfunction

endpackage

// File: rtl/fp_round_incr.sv
// Rounding increment decision from sign, lsb, guard and sticky.
// Directed modes are built only when FP_NORM_DIRECTED_ROUND_EN is defined.
module fp_round_incr
    import fp_mult_pkg::*;
(
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    input  logic [2:0] rnd,
    output logic       inc
);

`ifdef FP_NORM_DIRECTED_ROUND_EN
    always_comb begin
        inc = guard & (sticky | lsb);
        case (rnd_mode_t'(rnd))
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & (guard | sticky);
            RUP:     inc = !sign & (guard | sticky);
            RMM:     inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase
    end
`else
    // Nearest-even only; mode and sign do not influence the increment.
    logic unused_dir;
    assign unused_dir = sign ^ (^rnd);
    assign inc = guard & (sticky | lsb);
`endif

endmodule

// File: rtl/fp_norm_round_pipe.sv
// Two-stage normalise (stage 1) and round/pack (stage 2) back end for fp_mult.
// FP_NORM_DIRECTED_ROUND_EN enables RTZ/RDN/RUP/RMM; otherwise RNE only.
module fp_norm_round_pipe
    import fp_mult_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*(MAN_W+1)-1:0]   in_prod,
    input  logic signed [EXP_W+1:0]  in_exp,
    input  logic                     in_sign,
    input  logic [2:0]               in_rnd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic                     out_ovf,
    output logic                     out_unf,
    output logic                     out_inexact
);

    localparam int PW = 2 * (MAN_W + 1);
    localparam int EW = EXP_W + 2;
    localparam logic [EXP_W-1:0]     EXP_INF = EXP_W'(exp_inf(EXP_W));
    localparam logic [EXP_W-1:0]     EXP_MAX = EXP_W'(exp_max(EXP_W));
    localparam logic signed [EW-1:0] OVF_EXP = EW'(exp_inf(EXP_W));

    typedef struct packed {
        logic                 sign;
        logic signed [EW-1:0] exp;
        logic [MAN_W-1:0]     frac;
        logic                 guard;
        logic                 sticky;
        logic [2:0]           rnd;
    } norm_t;

    norm_t s1_d, s1_q;
    logic  v1, v2;
    logic  adv2;

    // Valid/ready: a beat moves when valid && ready; each stage refills when
    // empty or when the stage after it is taking its beat this cycle.
    assign adv2      = !v2 || out_ready;
    assign in_ready  = !v1 || adv2;
    assign out_valid = v2;

    always_comb begin
        s1_d.sign = in_sign;
        s1_d.rnd  = in_rnd;
        if (in_prod[PW-1]) begin
            s1_d.frac   = in_prod[PW-2 -: MAN_W];
            s1_d.guard  = in_prod[PW-2-MAN_W];
            s1_d.sticky = |in_prod[PW-3-MAN_W:0];
            s1_d.exp    = in_exp + EW'(1);
        end else begin
            s1_d.frac   = in_prod[PW-3 -: MAN_W];
            s1_d.guard  = in_prod[PW-3-MAN_W];
            s1_d.sticky = |in_prod[PW-4-MAN_W:0];
            s1_d.exp    = in_exp;
        end
    end

    logic                     inc;
    logic [MAN_W:0]           sum;
    logic signed [EW-1:0]     exp_r;
    logic                     ovf, unf, away;
    logic [EXP_W+MAN_W:0]     res_d;

    fp_round_incr u_incr (
        .sign   (s1_q.sign),
        .lsb    (s1_q.frac[0]),
        .guard  (s1_q.guard),
        .sticky (s1_q.sticky),
        .rnd    (s1_q.rnd),
        .inc    (inc)
    );

    // A carry out of the fraction leaves it all zeros, so only exp moves.
    assign sum   = {1'b0, s1_q.frac} + (MAN_W+1)'(inc);
    assign exp_r = s1_q.exp + EW'(sum[MAN_W]);
    assign ovf   = (exp_r >= OVF_EXP);
    assign unf   = !ovf && (exp_r[EW-1] || (exp_r == '0));

`ifdef FP_NORM_DIRECTED_ROUND_EN
    always_comb begin
        case (rnd_mode_t'(s1_q.rnd))
            RTZ:     away = 1'b0;
            RDN:     away = s1_q.sign;
            RUP:     away = !s1_q.sign;
            default: away = 1'b1;
        endcase
    end
`else
    assign away = 1'b1;
`endif

    always_comb begin
        if (ovf) begin
            res_d = away ? {s1_q.sign, EXP_INF, {MAN_W{1'b0}}}
                         : {s1_q.sign, EXP_MAX, {MAN_W{1'b1}}};
        end else if (unf) begin
            res_d = {s1_q.sign, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            res_d = {s1_q.sign, exp_r[EXP_W-1:0], sum[MAN_W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            s1_q        <= '0;
            out_result  <= '0;
            out_ovf     <= 1'b0;
            out_unf     <= 1'b0;
            out_inexact <= 1'b0;
        end else begin
            if (in_ready) begin
                v1 <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    out_result  <= res_d;
                    out_ovf     <= ovf;
                    out_unf     <= unf;
                    out_inexact <= s1_q.guard | s1_q.sticky | ovf | unf;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Self-checking bench for fp_norm_round_pipe (EXP_W=8, MAN_W=23): vector table
// streamed through a queue scoreboard, plus latency, backpressure and reset sequences.
module tb_fp_norm_round_pipe;
    import fp_mult_pkg::*;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int PW    = 48;
    localparam int RW    = 32;
`ifdef FP_NORM_DIRECTED_ROUND_EN
    localparam bit DIR = 1'b1;
`else
    localparam bit DIR = 1'b0;
`endif

    typedef struct {
        logic [PW-1:0] prod;
        logic [9:0]    exp;
        logic          sign;
        logic [2:0]    rnd;
        logic [RW-1:0] res;
        logic          ovf;
        logic          unf;
        logic          inx;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PW-1:0]     in_prod = '0;
    logic signed [9:0] in_exp = '0;
    logic              in_sign = 1'b0;
    logic [2:0]        in_rnd = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [RW-1:0]     out_result;
    logic              out_ovf, out_unf, out_inexact;

    vec_t              vt[$];
    logic [RW+2:0]     exp_q[$];
    logic [RW+2:0]     cur_exp = '0;
    int                n_cmp = 0;
    int                n_err = 0;
    bit                done = 1'b0;

    always #5 clk = ~clk;

    fp_norm_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_exp(in_exp), .in_sign(in_sign), .in_rnd(in_rnd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf),
        .out_inexact(out_inexact)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic add(input logic [PW-1:0] prod, input logic [9:0] exp, input logic sign,
                       input logic [2:0] rnd, input logic [RW-1:0] res,
                       input logic ovf, input logic unf, input logic inx);
        vec_t v;
        v.prod = prod; v.exp = exp; v.sign = sign; v.rnd = rnd;
        v.res = res; v.ovf = ovf; v.unf = unf; v.inx = inx;
        vt.push_back(v);
    endtask

    // Scoreboard: expected pushed when a beat is accepted, popped when one leaves.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h with no beat outstanding", out_result);
                end else if (out_ready) begin
                    check("result", {out_result, out_ovf, out_unf, out_inexact}, exp_q.pop_front());
                end else begin
                    check("held_output", {out_result, out_ovf, out_unf, out_inexact}, exp_q[0]);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    task automatic drive(input int i);
        in_prod  = vt[i].prod;
        in_exp   = vt[i].exp;
        in_sign  = vt[i].sign;
        in_rnd   = vt[i].rnd;
        in_valid = 1'b1;
        cur_exp  = {vt[i].res, vt[i].ovf, vt[i].unf, vt[i].inx};
    endtask

    task automatic send(input int i);
        bit ok = 1'b0;
        drive(i);
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 64'(ok), 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(posedge clk);
            #2;
            c++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int lat;
        bit seen;

        add(48'h4000_0000_0000, 10'd127, 0, 3'd0, 32'h3F80_0000, 0, 0, 0);
        add(48'h8000_0000_0000, 10'd127, 0, 3'd0, 32'h4000_0000, 0, 0, 0);
        add(48'h7FFF_FFC0_0000, 10'd127, 0, 3'd0, 32'h4000_0000, 0, 0, 1);
        add(48'h4000_0040_0000, 10'd127, 0, 3'd0, 32'h3F80_0000, 0, 0, 1);
        add(48'h4000_0040_0001, 10'd127, 0, 3'd0, 32'h3F80_0001, 0, 0, 1);
        add(48'h4000_00C0_0000, 10'd127, 0, 3'd0, 32'h3F80_0002, 0, 0, 1);
        add(48'h4000_0020_0000, 10'd127, 0, 3'd0, 32'h3F80_0000, 0, 0, 1);
        add(48'h8000_0080_0000, 10'd127, 0, 3'd0, 32'h4000_0000, 0, 0, 1);
        add(48'h8000_0180_0000, 10'd127, 0, 3'd0, 32'h4000_0002, 0, 0, 1);
        add(48'h8000_0000_0001, 10'd127, 0, 3'd0, 32'h4000_0000, 0, 0, 1);
        add(48'hC000_0000_0000, 10'd127, 1, 3'd0, 32'hC040_0000, 0, 0, 0);
        add(48'h8000_0000_0000, 10'd254, 0, 3'd0, 32'h7F80_0000, 1, 0, 1);
        add(48'h8000_0000_0000, 10'd254, 0, 3'd1, DIR ? 32'h7F7F_FFFF : 32'h7F80_0000, 1, 0, 1);
        add(48'h4000_0000_0000, 10'd0,   0, 3'd0, 32'h0000_0000, 0, 1, 1);
        add(48'h4000_0000_0000, 10'd1,   0, 3'd0, 32'h0080_0000, 0, 0, 0);
        add(48'h4000_0000_0000, 10'd254, 0, 3'd0, 32'h7F00_0000, 0, 0, 0);
        add(48'h7FFF_FFC0_0000, 10'd254, 0, 3'd0, 32'h7F80_0000, 1, 0, 1);
        add(48'h4000_0000_0000, 10'h3FB, 1, 3'd0, 32'h8000_0000, 0, 1, 1);
        add(48'h8000_0000_0000, 10'd0,   0, 3'd0, 32'h0080_0000, 0, 0, 0);
        add(48'h8000_0000_0000, 10'h3FF, 0, 3'd0, 32'h0000_0000, 0, 1, 1);
        add(48'h4000_0000_0000, 10'd255, 1, 3'd0, 32'hFF80_0000, 1, 0, 1);
        add(48'h4000_0040_0000, 10'd127, 0, 3'd3, DIR ? 32'h3F80_0001 : 32'h3F80_0000, 0, 0, 1);
        add(48'h4000_0040_0000, 10'd127, 1, 3'd2, DIR ? 32'hBF80_0001 : 32'hBF80_0000, 0, 0, 1);
        add(48'h4000_0040_0000, 10'd127, 0, 3'd4, DIR ? 32'h3F80_0001 : 32'h3F80_0000, 0, 0, 1);
        add(48'h4000_00C0_0000, 10'd127, 0, 3'd5, 32'h3F80_0002, 0, 0, 1);
        add(48'h4000_0040_0001, 10'd127, 0, 3'd1, DIR ? 32'h3F80_0000 : 32'h3F80_0001, 0, 0, 1);
        add(48'h4000_0020_0000, 10'd127, 0, 3'd3, DIR ? 32'h3F80_0001 : 32'h3F80_0000, 0, 0, 1);
        add(48'h4000_0040_0000, 10'd127, 0, 3'd2, 32'h3F80_0000, 0, 0, 1);
        add(48'h4000_0000_0000, 10'd127, 0, 3'd3, 32'h3F80_0000, 0, 0, 0);
        add(48'h8000_0000_0000, 10'd254, 0, 3'd2, DIR ? 32'h7F7F_FFFF : 32'h7F80_0000, 1, 0, 1);
        add(48'h8000_0000_0000, 10'd254, 1, 3'd3, DIR ? 32'hFF7F_FFFF : 32'hFF80_0000, 1, 0, 1);
        add(48'h8000_0000_0000, 10'd254, 1, 3'd2, 32'hFF80_0000, 1, 0, 1);
        add(48'h8000_0000_0000, 10'd254, 0, 3'd4, 32'h7F80_0000, 1, 0, 1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_word", {out_result, out_ovf, out_unf, out_inexact}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid_post", 64'(out_valid), 64'd0);

        // Latency with no stall
        @(posedge clk);
        #1;
        drive(0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd2);
        drain();

        // Full table, back-to-back
        for (int i = 0; i < vt.size(); i++) send(i);
        drain();

        // Table again under random backpressure and input gaps
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < vt.size(); i++) begin
                    send(i);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Four beats against a stalled output: two fill the pipe, then in_ready drops
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive(0);
        @(negedge clk);
        check("stall_ready_beat0", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        drive(1);
        @(negedge clk);
        check("stall_ready_beat1", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        drive(2);
        @(negedge clk);
        check("stall_ready_full", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_ready_held", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(2);
        send(3);
        drain();

        // Reset with two beats in flight
        send(4);
        send(5);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_word", {out_result, out_ovf, out_unf, out_inexact}, 64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("midrst_no_output", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        send(6);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
